gmsk_demodulate: RTL and testbench

//  Non-coherent GMSK I/Q demodulator: receive-side counterpart of the GMSK I/Q modulator.
//  Per strobed sample, computes the phase-rotation cross product I[n-1]*Q[n] - Q[n-1]*I[n].

---
 rtl/gmsk_pkg.sv | 11 +
 rtl/gmsk_demodulate_if.sv | 30 +++
 rtl/gmsk_xprod.sv | 80 ++++++++
 rtl/gmsk_demodulate.sv | 108 ++++++++++
 tb/tb_gmsk_demodulate.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/gmsk_pkg.sv
// gmsk_pkg: constants shared by the GMSK modulator and demodulator so both
// ends of the link agree on sample width and samples per symbol.
package gmsk_pkg;

    localparam int GMSK_SAMPLE_BITS        = 8;
    localparam int GMSK_SAMPLES_PER_SYMBOL = 31;
    localparam int GMSK_CNT_BITS           = 5;
    localparam int GMSK_ACC_BITS           = 2*GMSK_SAMPLE_BITS + 1 + GMSK_CNT_BITS;
    localparam int GMSK_SOFT_BITS          = 8;

endpackage

// File: rtl/gmsk_demodulate_if.sv
// gmsk_demodulate_if: sample-in / symbol-out bundle of the GMSK demodulator.
// The soft-decision signal exists only when GMSK_DEMOD_SOFT_EN is defined.
// master = sample source / symbol consumer, slave = demodulator.
interface gmsk_demodulate_if
    import gmsk_pkg::*;
#(
    parameter int SAMPLE_BITS = GMSK_SAMPLE_BITS
) ();

    logic                          sample_strobe;
    logic signed [SAMPLE_BITS-1:0] inphase_in;
    logic signed [SAMPLE_BITS-1:0] quadrature_in;
    logic                          symbol_align;
    logic                          symbol_out;
    logic                          symbol_valid;
`ifdef GMSK_DEMOD_SOFT_EN
    logic signed [GMSK_SOFT_BITS-1:0] symbol_soft_out;

    modport master (output sample_strobe, inphase_in, quadrature_in, symbol_align,
                    input  symbol_out, symbol_valid, symbol_soft_out);
    modport slave  (input  sample_strobe, inphase_in, quadrature_in, symbol_align,
                    output symbol_out, symbol_valid, symbol_soft_out);
`else
    modport master (output sample_strobe, inphase_in, quadrature_in, symbol_align,
                    input  symbol_out, symbol_valid);
    modport slave  (input  sample_strobe, inphase_in, quadrature_in, symbol_align,
                    output symbol_out, symbol_valid);
`endif

endinterface

// File: rtl/gmsk_xprod.sv
// gmsk_xprod: cross-product pipeline I[n-1]*Q[n] - Q[n-1]*I[n].
// S1 registers the new and previous sample, S2 forms both products,
// S3 forms their difference combinationally for the accumulator register.
// A flush drops every sample already in flight; the sample strobed in the
// same cycle is kept.
module gmsk_xprod
    import gmsk_pkg::*;
#(
    parameter int SAMPLE_BITS = GMSK_SAMPLE_BITS,
    parameter int CNT_BITS    = GMSK_CNT_BITS
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          strobe,
    input  logic                          flush,
    input  logic signed [SAMPLE_BITS-1:0] i_in,
    input  logic signed [SAMPLE_BITS-1:0] q_in,
    input  logic        [CNT_BITS-1:0]    idx_in,
    output logic                          vld_p2,
    output logic        [CNT_BITS-1:0]    idx_p2,
    output logic signed [2*SAMPLE_BITS:0] diff_p3
);

    localparam int PROD_W = 2*SAMPLE_BITS;
    localparam int DIFF_W = PROD_W + 1;

    logic signed [SAMPLE_BITS-1:0] i_p1, q_p1, ip_p1, qp_p1;
    logic                          vld_p1, pv_p1, seen;
    logic        [CNT_BITS-1:0]    idx_p1;
    logic signed [PROD_W-1:0]      p1_p2, p2_p2;
    logic                          pv_p2;

    // S1: capture the strobed sample; the previously captured one becomes I/Q[n-1].
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_p1   <= '0;
            q_p1   <= '0;
            ip_p1  <= '0;
            qp_p1  <= '0;
            pv_p1  <= 1'b0;
            seen   <= 1'b0;
            idx_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= strobe;
            if (strobe) begin
                ip_p1  <= i_p1;
                qp_p1  <= q_p1;
                i_p1   <= i_in;
                q_p1   <= q_in;
                pv_p1  <= seen;
                seen   <= 1'b1;
                idx_p1 <= idx_in;
            end
        end
    end

    // S2: the two cross products, full width so -128*-128 is exact.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p1_p2  <= '0;
            p2_p2  <= '0;
            pv_p2  <= 1'b0;
            idx_p2 <= '0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1 && !flush;
            if (vld_p1) begin
                p1_p2  <= PROD_W'(ip_p1) * PROD_W'(q_p1);
                p2_p2  <= PROD_W'(qp_p1) * PROD_W'(i_p1);
                pv_p2  <= pv_p1;
                idx_p2 <= idx_p1;
            end
        end
    end

    // S3: rotation term; the first sample after reset has no predecessor.
    assign diff_p3 = pv_p2 ? (DIFF_W'(p1_p2) - DIFF_W'(p2_p2)) : '0;

endmodule

// File: rtl/gmsk_demodulate.sv
// gmsk_demodulate: non-coherent GMSK I/Q demodulator. Integrates the
// cross-product rotation term over each symbol and slices its sign.
// Optional feature macro: GMSK_DEMOD_SOFT_EN adds a saturated 8-bit soft decision.
module gmsk_demodulate
    import gmsk_pkg::*;
#(
    parameter int SAMPLE_BITS        = GMSK_SAMPLE_BITS,
    parameter int SAMPLES_PER_SYMBOL = GMSK_SAMPLES_PER_SYMBOL,
    parameter int CNT_BITS           = GMSK_CNT_BITS,
    parameter int ACC_BITS           = GMSK_ACC_BITS
) (
    input  logic             clock,
    input  logic             reset_n,
    gmsk_demodulate_if.slave bus
);

    localparam int                  DIFF_W   = 2*SAMPLE_BITS + 1;
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(SAMPLES_PER_SYMBOL - 1);

    logic        [CNT_BITS-1:0] cnt, idx_in, idx_p2;
    logic                       vld_p2, acc_en;
    logic signed [DIFF_W-1:0]   diff_p3;
    logic signed [ACC_BITS-1:0] acc, acc_next, diff_ext;
    logic                       dec_vld, dec_bit;

    // Index tag of the sample strobed this cycle; a coincident align makes it 0.
    assign idx_in = bus.symbol_align ? '0 : cnt;

    // Symbol-phase counter; an align without strobe makes the next sample index 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (bus.sample_strobe) begin
            cnt <= (idx_in == LAST_IDX) ? '0 : idx_in + CNT_BITS'(1);
        end else if (bus.symbol_align) begin
            cnt <= '0;
        end
    end

    gmsk_xprod #(
        .SAMPLE_BITS (SAMPLE_BITS),
        .CNT_BITS    (CNT_BITS)
    ) u_xprod (
        .clock   (clock),
        .reset_n (reset_n),
        .strobe  (bus.sample_strobe),
        .flush   (bus.symbol_align),
        .i_in    (bus.inphase_in),
        .q_in    (bus.quadrature_in),
        .idx_in  (idx_in),
        .vld_p2  (vld_p2),
        .idx_p2  (idx_p2),
        .diff_p3 (diff_p3)
    );

    // Samples of a truncated symbol still at S3 when align arrives are dropped.
    assign acc_en   = vld_p2 && !bus.symbol_align;
    assign diff_ext = ACC_BITS'(diff_p3);
    assign acc_next = (idx_p2 == '0) ? diff_ext : acc + diff_ext;

    // Accumulate per symbol; slice the final sum (zero keeps the previous bit).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            dec_vld <= 1'b0;
            dec_bit <= 1'b0;
        end else begin
            dec_vld <= 1'b0;
            if (acc_en) begin
                acc <= acc_next;
                if (idx_p2 == LAST_IDX) begin
                    dec_vld <= 1'b1;
                    if (acc_next[ACC_BITS-1]) begin
                        dec_bit <= 1'b0;
                    end else if (acc_next != '0) begin
                        dec_bit <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.symbol_out   = dec_bit;
    assign bus.symbol_valid = dec_vld;

`ifdef GMSK_DEMOD_SOFT_EN
    logic signed [GMSK_SOFT_BITS-1:0] soft;

    // Top bits of the sum equal acc >>> (ACC_BITS-8); clamp -128 to keep the range symmetric.
    function automatic logic signed [GMSK_SOFT_BITS-1:0] soft_sat(
        input logic signed [GMSK_SOFT_BITS-1:0] top
    );
        return (top == {1'b1, {(GMSK_SOFT_BITS-1){1'b0}}}) ? -GMSK_SOFT_BITS'(127) : top;
    endfunction

    // Soft decision, updated together with the hard decision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            soft <= '0;
        end else if (acc_en && idx_p2 == LAST_IDX) begin
            soft <= soft_sat(acc_next[ACC_BITS-1 -: GMSK_SOFT_BITS]);
        end
    end

    assign bus.symbol_soft_out = soft;
`endif

endmodule

// File: tb/tb_gmsk_demodulate.sv
// tb_gmsk_demodulate: directed bench for gmsk_demodulate. An ideal quadrature
// phasor stepping a quarter turn per sample (CCW for bit 1, CW for bit 0)
// stands in for the modulator, so decided bits appear with no filter delay.
module tb_gmsk_demodulate;
    import gmsk_pkg::*;

    localparam int SPS = GMSK_SAMPLES_PER_SYMBOL;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   last_strobe_cyc = 0;
    int   ph = 0;
    int   cp = 3;

    // Phasor of magnitude 100 and the four full-scale corners A,B,C,D (CCW order).
    int ph_i[4] = '{100, 0, -100, 0};
    int ph_q[4] = '{0, 100, 0, -100};
    int cr_i[4] = '{-128, 127, 127, -128};
    int cr_q[4] = '{-128, -128, 127, 127};

    logic pulse_q[$];
    int   pcyc_q[$];
`ifdef GMSK_DEMOD_SOFT_EN
    logic signed [7:0] soft_q[$];
`endif

    gmsk_demodulate_if bus ();

    gmsk_demodulate dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every decision pulse on the falling edge.
    always @(negedge clock) begin
        if (bus.symbol_valid === 1'b1) begin
            pulse_q.push_back(bus.symbol_out);
            pcyc_q.push_back(cyc);
`ifdef GMSK_DEMOD_SOFT_EN
            soft_q.push_back(bus.symbol_soft_out);
`endif
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] i, input logic [7:0] q, input logic al);
        bus.sample_strobe = 1'b1;
        bus.inphase_in    = i;
        bus.quadrature_in = q;
        bus.symbol_align  = al;
        last_strobe_cyc   = cyc;
        @(posedge clock); #1;
        bus.sample_strobe = 1'b0;
        bus.symbol_align  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_phasor(input logic ccw, input int n, input logic al);
        for (int k = 0; k < n; k++) begin
            ph = ccw ? (ph + 1) % 4 : (ph + 3) % 4;
            send(8'(ph_i[ph]), 8'(ph_q[ph]), al && (k == 0));
        end
    endtask

    task automatic send_corner(input logic ccw, input int n, input logic al);
        for (int k = 0; k < n; k++) begin
            cp = ccw ? (cp + 1) % 4 : (cp + 3) % 4;
            send(8'(cr_i[cp]), 8'(cr_q[cp]), al && (k == 0));
        end
    endtask

    task automatic send_zero(input int n);
        for (int k = 0; k < n; k++) send(8'd0, 8'd0, 1'b0);
    endtask

    task automatic clear_log();
        pulse_q.delete();
        pcyc_q.delete();
`ifdef GMSK_DEMOD_SOFT_EN
        soft_q.delete();
`endif
    endtask

    // Pulse count and decided bits, oldest first = exp_bits[n-1].
    task automatic chk_pulses(input string tag, input logic [15:0] exp_bits, input int n);
        chk({tag, "_count"}, pulse_q.size(), n);
        for (int k = 0; k < n && k < pulse_q.size(); k++)
            chk($sformatf("%s_bit%0d", tag, k), pulse_q[k], exp_bits[n-1-k]);
    endtask

    // Last pulse must follow the last strobe by exactly three clocks.
    task automatic chk_lat(input string tag);
        chk(tag, (pcyc_q.size() > 0) ? pcyc_q[pcyc_q.size()-1] - last_strobe_cyc : -1, 3);
    endtask

    initial begin
        bus.sample_strobe = 1'b0;
        bus.inphase_in    = '0;
        bus.quadrature_in = '0;
        bus.symbol_align  = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out", bus.symbol_out, 0);
        chk("rst_vld", bus.symbol_valid, 0);
`ifdef GMSK_DEMOD_SOFT_EN
        chk("rst_soft", bus.symbol_soft_out, 0);
`endif
        reset_n = 1'b1;
        idle(1);

        // Loopback pattern 1011001110, aligned on the first sample
        clear_log();
        for (int k = 0; k < 10; k++) send_phasor(logic'(10'b1011001110 >> (9 - k)), SPS, k == 0);
        idle(6);
        chk_pulses("t1", 16'b1011001110, 10);
        chk_lat("t1_lat");
`ifdef GMSK_DEMOD_SOFT_EN
        chk("t1_soft", (soft_q.size() == 10) ? soft_q[9] : 8'sd0, -19);
`endif

        // Constant streams, strobes every clock: three 1s then three 0s
        clear_log();
        for (int k = 0; k < 3; k++) send_phasor(1'b1, SPS, 1'b0);
        for (int k = 0; k < 3; k++) send_phasor(1'b0, SPS, 1'b0);
        idle(6);
        chk_pulses("t2", 16'b111000, 6);
        chk("t2_gap1", (pcyc_q.size() > 1) ? pcyc_q[1] - pcyc_q[0] : -1, SPS);
        chk("t2_gap4", (pcyc_q.size() > 4) ? pcyc_q[4] - pcyc_q[3] : -1, SPS);

        // Zero-sum symbols repeat the previous decision (1 then 0)
        clear_log();
        send_phasor(1'b1, SPS, 1'b0);
        send_zero(SPS);
        send_phasor(1'b0, SPS, 1'b0);
        send_zero(SPS);
        idle(6);
        chk_pulses("t4", 16'b1100, 4);

        // Full-scale corners: sums near +/-1e6 must not wrap (+975375, -1008015)
        clear_log();
        cp = 3;
        send_corner(1'b1, SPS, 1'b1);
        send_corner(1'b0, SPS, 1'b0);
        idle(6);
        chk_pulses("t3", 16'b10, 2);
`ifdef GMSK_DEMOD_SOFT_EN
        chk("t3_soft_pos", (soft_q.size() > 0) ? soft_q[0] : 8'sd0, 59);
        chk("t3_soft_neg", (soft_q.size() > 1) ? soft_q[1] : 8'sd0, -62);
`endif

        // Align with coincident strobe at idx 12: truncated symbol gives no pulse
        clear_log();
        send_phasor(1'b1, 12, 1'b0);
        send_phasor(1'b0, SPS, 1'b1);
        idle(6);
        chk_pulses("t5", 16'b0, 1);
        chk_lat("t5_lat");

        // Align without strobe at idx 7: next strobed sample is idx 0
        clear_log();
        send_phasor(1'b1, 7, 1'b0);
        idle(2);
        bus.symbol_align = 1'b1;
        idle(1);
        bus.symbol_align = 1'b0;
        send_phasor(1'b1, SPS, 1'b0);
        idle(6);
        chk_pulses("t5b", 16'b1, 1);
        chk_lat("t5b_lat");

        // Reset at idx 20 clears outputs at once; counting restarts from 0
        clear_log();
        send_phasor(1'b1, 20, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_out", bus.symbol_out, 0);
        chk("t6_async_vld", bus.symbol_valid, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(1);
        send_phasor(1'b1, SPS, 1'b0);
        idle(6);
        chk_pulses("t6", 16'b1, 1);
        chk_lat("t6_lat");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
